// File: rtl/fclass_gen_if.sv
// Request/stream bundle for the class-targeted binary32 generator.
// The slave side is the generator; the master side is the requester/consumer.
interface fclass_gen_if #(
    parameter int COUNT_W = 8
) ();
    logic               req_valid;
    logic               req_ready;
    logic [9:0]         req_class;
    logic [COUNT_W-1:0] req_count;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               out_last;
    logic               err;
    logic               busy;

    modport master (
        output req_valid, req_class, req_count, out_ready,
        input  req_ready, out_valid, out_data, out_last, err, busy
    );

    modport slave (
        input  req_valid, req_class, req_count, out_ready,
        output req_ready, out_valid, out_data, out_last, err, busy
    );
endinterface

// File: rtl/fclass_gen_s.sv
// Inverse FCLASS.S: streams req_count pseudo-random binary32 values of one requested class.
// Randomness comes from a 32-bit Galois LFSR that advances only when a beat transfers.
module fclass_gen_s #(
    parameter int          COUNT_W = 8,
    parameter logic [31:0] SEED    = 32'hACE12468
) (
    input  logic        clk,
    input  logic        rst,
    fclass_gen_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [9:0]         class_q, class_d;
    logic               err_q, err_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        logic [31:0] nxt;
        nxt = r >> 1;
        if (r[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    function automatic logic is_one_hot(input logic [9:0] c);
        return (c != 10'd0) && ((c & (c - 10'd1)) == 10'd0);
    endfunction

    // Classes 0..3 are the negative finite/infinite classes; NaNs take their sign from r[31].
    function automatic logic [31:0] encode(input logic [9:0] cls, input logic [31:0] r);
        logic        s;
        logic [7:0]  e_norm;
        logic [22:0] m_sub;
        logic [21:0] m_snan;
        logic [31:0] val;
        s      = |cls[3:0];
        e_norm = r[30:23];
        if (e_norm == 8'h00) begin
            e_norm = 8'h01;
        end else if (e_norm == 8'hFF) begin
            e_norm = 8'hFE;
        end
        m_sub  = (r[22:0] == 23'd0) ? 23'h000001 : r[22:0];
        m_snan = (r[21:0] == 22'd0) ? 22'h000001 : r[21:0];
        val    = 32'h0;
        if (cls[0] || cls[7]) begin
            val = {s, 8'hFF, 23'h0};
        end else if (cls[1] || cls[6]) begin
            val = {s, e_norm, r[22:0]};
        end else if (cls[2] || cls[5]) begin
            val = {s, 8'h00, m_sub};
        end else if (cls[3] || cls[4]) begin
            val = {s, 31'h0};
        end else if (cls[8]) begin
            val = {r[31], 8'hFF, 1'b0, m_snan};
        end else if (cls[9]) begin
            val = {r[31], 8'hFF, 1'b1, r[21:0]};
        end
        return val;
    endfunction

    logic xfer;
    logic last_beat;

    assign last_beat = (remaining_q == COUNT_W'(1));
    assign xfer      = (state_q == GEN) && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        class_d     = class_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!is_one_hot(bus.req_class) || (bus.req_count == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        class_d     = bus.req_class;
                        remaining_d = bus.req_count;
                        state_d     = GEN;
                    end
                end
            end
            GEN: begin
                if (xfer) begin
                    lfsr_d      = lfsr_step(lfsr_q);
                    remaining_d = remaining_q - COUNT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            remaining_q <= '0;
            class_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
            class_q     <= class_d;
            err_q       <= err_d;
        end
    end

    // out_data is a pure function of registers that only move on transfer, so it holds under backpressure
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == GEN);
    assign bus.out_valid = (state_q == GEN);
    assign bus.out_last  = (state_q == GEN) && last_beat;
    assign bus.out_data  = (state_q == GEN) ? encode(class_q, lfsr_q) : 32'h0;
    assign bus.err       = err_q;

endmodule
